// File: rtl/result_copy_scheduler_if.sv
// Job-source and copy-engine signals of result_copy_scheduler, grouped as one bundle.
// The master modport is the scheduler. The slave modport is the environment: the job sources and the engine.
interface result_copy_scheduler_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_offset;
    logic [NUM_REQ*32-1:0] req_words;
    logic [NUM_REQ*64-1:0] req_memory_addr;
    logic [NUM_REQ-1:0]    req_done;
    logic                  busy;
    logic                  copy_kick;
    logic                  copy_busy;
    logic [31:0]           copy_offset;
    logic [31:0]           copy_words;
    logic [63:0]           copy_memory_addr;

    modport master (
        input  req_valid, req_offset, req_words, req_memory_addr, copy_busy,
        output req_ready, req_done, busy, copy_kick, copy_offset, copy_words, copy_memory_addr
    );

    modport slave (
        output req_valid, req_offset, req_words, req_memory_addr, copy_busy,
        input  req_ready, req_done, busy, copy_kick, copy_offset, copy_words, copy_memory_addr
    );
endinterface

// File: rtl/result_copy_scheduler.sv
// Round-robin scheduler that splits per-requester copy jobs into bounded chunks
// and feeds them one at a time to a single simple_result_copy engine.
module result_copy_scheduler #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_CHUNK_WORDS = 1024,
    parameter int WORD_BYTES      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    result_copy_scheduler_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ARB, KICK, WAIT_START, WAIT_DONE, ADVANCE} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   active_q, active_d;
    logic [NUM_REQ-1:0]   done_pending_q, done_pending_d;
    logic [NUM_REQ-1:0]   zero_done_q, zero_done_d;
    logic [31:0]          remaining_q [NUM_REQ];
    logic [31:0]          remaining_d [NUM_REQ];
    logic [31:0]          cur_offset_q [NUM_REQ];
    logic [31:0]          cur_offset_d [NUM_REQ];
    logic [63:0]          cur_addr_q [NUM_REQ];
    logic [63:0]          cur_addr_d [NUM_REQ];
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [31:0]          copy_offset_q, copy_offset_d;
    logic [31:0]          copy_words_q, copy_words_d;
    logic [63:0]          copy_addr_q, copy_addr_d;
    logic [NUM_REQ-1:0]   ready;
    logic [IDX_W-1:0]     arb_idx;
    logic [IDX_W-1:0]     cand_idx;
    logic                 arb_found;
    int                   cand;
    logic [31:0]          chunk;

    assign ready = ~active_q & ~done_pending_q;

    // Search starts just after the last grant, so that index is picked only when it is the sole active job.
    always_comb begin
        arb_idx   = last_grant_q;
        arb_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_grant_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!arb_found && active_q[cand_idx]) begin
                arb_idx   = cand_idx;
                arb_found = 1'b1;
            end
        end
        chunk = (remaining_q[arb_idx] < 32'(MAX_CHUNK_WORDS)) ? remaining_q[arb_idx]
                                                                : 32'(MAX_CHUNK_WORDS);
    end

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        done_pending_d = '0;
        zero_done_d    = '0;
        remaining_d    = remaining_q;
        cur_offset_d   = cur_offset_q;
        cur_addr_d     = cur_addr_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        copy_offset_d  = copy_offset_q;
        copy_words_d   = copy_words_q;
        copy_addr_d    = copy_addr_q;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && ready[i]) begin
                remaining_d[i]  = bus.req_words[i*32 +: 32];
                cur_offset_d[i] = bus.req_offset[i*32 +: 32];
                cur_addr_d[i]   = bus.req_memory_addr[i*64 +: 64];
                if (bus.req_words[i*32 +: 32] != 32'd0) begin
                    active_d[i] = 1'b1;
                end else begin
                    zero_done_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (|active_q) state_d = ARB;
            end
            ARB: begin
                grant_d       = arb_idx;
                copy_offset_d = cur_offset_q[arb_idx];
                copy_words_d  = chunk;
                copy_addr_d   = cur_addr_q[arb_idx];
                state_d       = KICK;
            end
            KICK: state_d = WAIT_START;
            WAIT_START: begin
                if (bus.copy_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.copy_busy) state_d = ADVANCE;
            end
            ADVANCE: begin
                remaining_d[grant_q]  = remaining_q[grant_q] - copy_words_q;
                cur_offset_d[grant_q] = cur_offset_q[grant_q] + copy_words_q;
                cur_addr_d[grant_q]   = cur_addr_q[grant_q] + 64'(copy_words_q) * 64'(WORD_BYTES);
                if (remaining_d[grant_q] == 32'd0) begin
                    active_d[grant_q]       = 1'b0;
                    done_pending_d[grant_q] = 1'b1;
                end
                last_grant_d = grant_q;
                state_d      = (|active_d) ? ARB : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            active_q       <= '0;
            done_pending_q <= '0;
            zero_done_q    <= '0;
            last_grant_q   <= '0;
            grant_q        <= '0;
            copy_offset_q  <= '0;
            copy_words_q   <= '0;
            copy_addr_q    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                remaining_q[i]  <= '0;
                cur_offset_q[i] <= '0;
                cur_addr_q[i]   <= '0;
            end
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            done_pending_q <= done_pending_d;
            zero_done_q    <= zero_done_d;
            last_grant_q   <= last_grant_d;
            grant_q        <= grant_d;
            copy_offset_q  <= copy_offset_d;
            copy_words_q   <= copy_words_d;
            copy_addr_q    <= copy_addr_d;
            remaining_q    <= remaining_d;
            cur_offset_q   <= cur_offset_d;
            cur_addr_q     <= cur_addr_d;
        end
    end

    assign bus.req_ready        = ready;
    assign bus.req_done         = done_pending_q | zero_done_q;
    assign bus.busy             = (state_q != IDLE) || (|active_q);
    assign bus.copy_kick        = (state_q == KICK);
    assign bus.copy_offset      = copy_offset_q;
    assign bus.copy_words       = copy_words_q;
    assign bus.copy_memory_addr = copy_addr_q;
endmodule

// File: tb/tb_result_copy_scheduler.sv
// Directed bench for result_copy_scheduler with a behavioural copy engine.
// It logs kicks and done pulses and compares them against hand-computed vectors.
module tb_result_copy_scheduler;
    logic clk;
    logic reset;

    result_copy_scheduler_if #(.NUM_REQ(2)) bus ();

    result_copy_scheduler #(
        .NUM_REQ(2),
        .MAX_CHUNK_WORDS(1024),
        .WORD_BYTES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] off;
        logic [31:0] words;
        logic [63:0] addr;
        int          cyc;
    } kick_t;

    typedef struct {
        int          req;
        logic [31:0] off;
        logic [31:0] words;
        logic [63:0] addr;
        int          n_kicks;
        logic [31:0] first_words;
        logic [31:0] last_off;
        logic [31:0] last_words;
        logic [63:0] last_addr;
    } vec_t;

    kick_t kicks[$];
    int    dones[$];
    int    falls[$];
    int    cyc;
    int    eng_cnt;
    int    busy_len;
    int    overlap;
    int    errors;
    int    checks;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The engine model raises busy in the kick cycle and holds it for busy_len cycles.
    initial begin
        bus.copy_busy = 1'b0;
        eng_cnt  = 0;
        cyc      = 0;
        overlap  = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                eng_cnt = 0;
                bus.copy_busy = 1'b0;
            end else if (bus.copy_kick) begin
                if (eng_cnt != 0) overlap++;
                bus.copy_busy = 1'b1;
                eng_cnt = busy_len;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.copy_busy = 1'b0;
                    falls.push_back(cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.copy_kick)
                kicks.push_back('{bus.copy_offset, bus.copy_words, bus.copy_memory_addr, cyc});
            for (int i = 0; i < 2; i++)
                if (bus.req_done[i]) dones.push_back(i);
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int idx, input logic [31:0] off, input logic [31:0] words,
                                  input logic [63:0] addr);
        @(negedge clk);
        bus.req_offset[idx*32 +: 32]      = off;
        bus.req_words[idx*32 +: 32]       = words;
        bus.req_memory_addr[idx*64 +: 64] = addr;
        bus.req_valid[idx]                = 1'b1;
        @(negedge clk);
        bus.req_valid[idx]                = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((bus.busy || bus.copy_busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("[TB] FAIL %s: still busy after %0d cycles, required idle", name, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_logs();
        kicks.delete();
        dones.delete();
        falls.delete();
        overlap = 0;
    endtask

    vec_t        vecs[5];
    logic [31:0] rr_off[5];
    logic [63:0] rr_addr[5];
    int          n;

    initial begin
        errors   = 0;
        checks   = 0;
        busy_len = 4;
        reset    = 1'b1;
        bus.req_valid       = '0;
        bus.req_offset      = '0;
        bus.req_words       = '0;
        bus.req_memory_addr = '0;

        vecs[0] = '{0, 32'd0, 32'd2048, 64'habadcafe_deadbeef, 2, 32'd1024, 32'd1024, 32'd1024, 64'habadcafe_deaddeef};
        vecs[1] = '{0, 32'd100, 32'd1500, 64'h1000, 2, 32'd1024, 32'd1124, 32'd476, 64'h3000};
        vecs[2] = '{0, 32'd7, 32'd1, 64'h40, 1, 32'd1, 32'd7, 32'd1, 64'h40};
        vecs[3] = '{0, 32'hffff_ff00, 32'd1280, 64'hffff_ffff_ffff_f000, 2, 32'd1024, 32'h300, 32'd256, 64'h1000};
        vecs[4] = '{1, 32'd5, 32'd1024, 64'h8, 1, 32'd1024, 32'd5, 32'd1024, 64'h8};

        repeat (3) @(negedge clk);
        check_output("reset req_ready", 64'(bus.req_ready), 64'h3);
        check_output("reset req_done", 64'(bus.req_done), 64'h0);
        check_output("reset busy", 64'(bus.busy), 64'h0);
        check_output("reset copy_kick", 64'(bus.copy_kick), 64'h0);
        check_output("reset copy_words", 64'(bus.copy_words), 64'h0);
        check_output("reset copy_addr", bus.copy_memory_addr, 64'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            clear_logs();
            apply_stimulus(vecs[v].req, vecs[v].off, vecs[v].words, vecs[v].addr);
            wait_idle(2000, $sformatf("vec%0d idle", v));
            check_output($sformatf("vec%0d kick count", v), 64'(kicks.size()), 64'(vecs[v].n_kicks));
            if (kicks.size() > 0) begin
                check_output($sformatf("vec%0d first offset", v), 64'(kicks[0].off), 64'(vecs[v].off));
                check_output($sformatf("vec%0d first words", v), 64'(kicks[0].words), 64'(vecs[v].first_words));
                check_output($sformatf("vec%0d first addr", v), kicks[0].addr, vecs[v].addr);
                n = kicks.size() - 1;
                check_output($sformatf("vec%0d last offset", v), 64'(kicks[n].off), 64'(vecs[v].last_off));
                check_output($sformatf("vec%0d last words", v), 64'(kicks[n].words), 64'(vecs[v].last_words));
                check_output($sformatf("vec%0d last addr", v), kicks[n].addr, vecs[v].last_addr);
            end
            check_output($sformatf("vec%0d done count", v), 64'(dones.size()), 64'd1);
            if (dones.size() > 0)
                check_output($sformatf("vec%0d done index", v), 64'(dones[0]), 64'(vecs[v].req));
            check_output($sformatf("vec%0d busy after", v), 64'(bus.busy), 64'h0);
            check_output($sformatf("vec%0d ready after", v), 64'(bus.req_ready), 64'h3);
        end

        // Zero-length job: done pulses once, the slot never closes, and the engine is never kicked.
        clear_logs();
        @(negedge clk);
        bus.req_offset[63:32] = 32'd42;
        bus.req_words[63:32]  = 32'd0;
        bus.req_valid[1]      = 1'b1;
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        check_output("zero done pulse", 64'(bus.req_done), 64'h2);
        check_output("zero ready held", 64'(bus.req_ready[1]), 64'h1);
        check_output("zero busy", 64'(bus.busy), 64'h0);
        @(negedge clk);
        check_output("zero done one cycle", 64'(bus.req_done), 64'h0);
        repeat (10) @(negedge clk);
        check_output("zero no kick", 64'(kicks.size()), 64'h0);

        // Round robin: the previous grant was requester 1, so requester 0 goes first.
        clear_logs();
        rr_off  = '{32'd0, 32'd5000, 32'd1024, 32'd6024, 32'd2048};
        rr_addr = '{64'h0, 64'h10000, 64'h2000, 64'h12000, 64'h4000};
        @(negedge clk);
        bus.req_offset      = {32'd5000, 32'd0};
        bus.req_words       = {32'd2048, 32'd3072};
        bus.req_memory_addr = {64'h10000, 64'h0};
        bus.req_valid       = 2'b11;
        @(negedge clk);
        bus.req_valid = 2'b00;
        wait_idle(5000, "rr idle");
        check_output("rr kick count", 64'(kicks.size()), 64'd5);
        for (int k = 0; k < 5 && k < kicks.size(); k++) begin
            check_output($sformatf("rr kick%0d offset", k), 64'(kicks[k].off), 64'(rr_off[k]));
            check_output($sformatf("rr kick%0d words", k), 64'(kicks[k].words), 64'd1024);
            check_output($sformatf("rr kick%0d addr", k), kicks[k].addr, rr_addr[k]);
        end
        check_output("rr done count", 64'(dones.size()), 64'd2);
        if (dones.size() == 2) begin
            check_output("rr first done", 64'(dones[0]), 64'd1);
            check_output("rr second done", 64'(dones[1]), 64'd0);
        end

        // A slow engine: one kick per busy period, and the next kick arrives 3 cycles after busy falls.
        clear_logs();
        busy_len = 50;
        apply_stimulus(0, 32'd0, 32'd2048, 64'h100);
        repeat (10) @(negedge clk);
        check_output("bp ready while active", 64'(bus.req_ready[0]), 64'h0);
        check_output("bp busy while active", 64'(bus.busy), 64'h1);
        wait_idle(1000, "bp idle");
        check_output("bp kick count", 64'(kicks.size()), 64'd2);
        check_output("bp overlap kicks", 64'(overlap), 64'd0);
        if (kicks.size() == 2 && falls.size() > 0) begin
            check_output("bp fall to kick", 64'(kicks[1].cyc - falls[0]), 64'd3);
            check_output("bp kick spacing", 64'(kicks[1].cyc - kicks[0].cyc), 64'd53);
            check_output("bp second addr", kicks[1].addr, 64'h2100);
        end

        // Reset while the engine is mid-chunk drops the job silently.
        clear_logs();
        busy_len = 20;
        apply_stimulus(0, 32'd0, 32'd4096, 64'h500);
        n = 0;
        while (kicks.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("rst first kick seen", 64'(kicks.size() > 0), 64'h1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("rst async kick", 64'(bus.copy_kick), 64'h0);
        check_output("rst async busy", 64'(bus.busy), 64'h0);
        check_output("rst async ready", 64'(bus.req_ready), 64'h3);
        check_output("rst async done", 64'(bus.req_done), 64'h0);
        check_output("rst async offset", 64'(bus.copy_offset), 64'h0);
        check_output("rst async words", 64'(bus.copy_words), 64'h0);
        check_output("rst async addr", bus.copy_memory_addr, 64'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_logs();
        busy_len = 4;
        repeat (30) @(negedge clk);
        check_output("rst no done", 64'(dones.size()), 64'h0);
        check_output("rst no kick", 64'(kicks.size()), 64'h0);
        apply_stimulus(0, 32'd300, 32'd10, 64'h900);
        wait_idle(500, "rst new job idle");
        check_output("rst new kick count", 64'(kicks.size()), 64'd1);
        if (kicks.size() > 0) begin
            check_output("rst new offset", 64'(kicks[0].off), 64'd300);
            check_output("rst new words", 64'(kicks[0].words), 64'd10);
            check_output("rst new addr", kicks[0].addr, 64'h900);
        end
        check_output("rst new done", 64'(dones.size()), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
